dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder: the memory end of the CPU Mem-stage load/store interface.
// - Accepts one request at a time (word/byte store; word, signed-byte or unsigned-byte load) over valid/ready.
// - Returns the response after LATENCY wait cycles; lets the pipeline be exercised against a non-zero-latency memory.
// PARAMETERS
// - DEPTH    1024  number of 32-bit words in the array; power of two
// - LATENCY  2     wait cycles between accept and response; legal 0..15
// PORTS
// - clk             in   1   rising-edge clock
// - rst             in   1   asynchronous reset, active-low (0 = reset)
// - req_valid       in   1   request present
// - req_ready       out  1   responder can accept
// - req_we          in   1   1 = store, 0 = load
// - req_byte        in   1   store width (WrByte): 1 = byte, 0 = word
// - req_load_byte   in   2   load type (LoadByte): 00 word, 01 signed byte, 10 unsigned byte, 11 = word
// - req_addr        in   32  byte address
// - req_wdata       in   32  store data; a byte store uses [7:0]
// - resp_valid      out  1   response present
// - resp_ready      in   1   requester takes the response
// - resp_rdata      out  32  load data; 0 for stores
// - resp_err        out  1   error response (only with DMEM_ERR_EN)
// BEHAVIOUR
// - Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
// - Array contents are not reset.
// - FSM states are IDLE, WAIT and RESP:
// -   IDLE: req_ready=1. On req_valid, capture all req_* fields.
// -     LATENCY=0: go to RESP.
// -     LATENCY>0: go to WAIT with counter=LATENCY-1.
// -   WAIT: req_ready=0. Counter decrements each cycle. On the cycle the counter is 0, go to RESP.
// -   RESP: resp_valid=1. Outputs hold stable until resp_ready=1, then return to IDLE.
// -   No accept in the handshake cycle: one bubble between back-to-back requests.
// - Commit point: the cycle of entry into RESP. Stores write the array and loads sample it in that cycle.
// - Latency: accept at edge N gives resp_valid high from edge N+1+LATENCY.
// - Addressing is little-endian.
// -   Word index = req_addr[log2(DEPTH)+1:2]. Without DMEM_ERR_EN, higher bits are ignored (wrap mod DEPTH).
// -   Byte lane = req_addr[1:0]; byte lane 0 = bits [7:0].
// - Word store writes all 4 lanes. Byte store writes only lane req_addr[1:0] with req_wdata[7:0].
// - Word load returns the whole word; req_addr[1:0] is ignored.
// - Signed-byte load returns {24{b[7]}, b}. Unsigned-byte load returns {24'b0, b}. b = the selected lane.
// - A load issued after a store to the same address returns the stored data (commits are serialised).
// - Reset mid-operation: a request in WAIT is dropped and its store is not committed.
// - Reset mid-operation: a response pending in RESP is discarded.
// - req_* inputs are ignored outside IDLE.
// CONFIGURATION
// - Macro DMEM_ERR_EN.
// - Defined:
// -   Word access with req_addr[1:0]!=0 gives resp_err=1.
// -   Word index >= DEPTH (any address bit above the index field set) gives resp_err=1.
// -   On an error, no array write, resp_rdata=0, same latency.
// - Undefined: resp_err is tied to 0, misaligned word access ignores [1:0], and out-of-range addresses wrap.
// STRUCTURE
// - Package dmem_pkg:
// -   load-type encodings LD_WORD=2'b00, LD_SBYTE=2'b01, LD_UBYTE=2'b10
// -   FSM state encoding IDLE/WAIT/RESP
// -   localparam AW=$clog2(DEPTH)
// - Sub-module dmem_lane_sel (combinational): byte-lane extract with sign/zero extend for loads.
// -   It also produces the byte-enable mask and the replicated write data for stores.
// - Top module holds the FSM, wait counter, request capture registers and the memory array.
// TESTING
// - Reset, then word store addr 0x10 data 0xDEADBEEF; word load 0x10.
// -   Required: rdata=0xDEADBEEF, resp_valid exactly LATENCY+1 edges after each accept.
// - Byte store 0xAB to addr 0x11 over 0x00000000; loads of addr 0x11.
// -   Required: word load 0x10 = 0x0000AB00.
// -   Required: signed-byte load 0x11 = 0xFFFFFFAB; unsigned-byte load 0x11 = 0x000000AB.
// - Backpressure: hold resp_ready=0 for 5 cycles in RESP.
// -   Required: resp_valid/rdata stable, req_ready=0, a new req_valid is ignored, accept only after return to IDLE.
// - Reset asserted during WAIT of a word store to 0x20 holding 0x12345678; reset released; word load 0x20.
// -   Required: returns the old value; outputs are at reset values while rst=0.
// - LATENCY=0 build: back-to-back store/load.
// -   Required: resp_valid 1 edge after accept; one-cycle bubble between transactions.
// - DMEM_ERR_EN build, word load addr 0x13: resp_err=1, rdata=0.
// - DMEM_ERR_EN build, word store to word index DEPTH: resp_err=1 and word 0 is unchanged.
// - Without DMEM_ERR_EN, word store to word index DEPTH aliases to word 0 and resp_err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and sizing for the data-memory responder.
// Optional feature macro used by dmem_responder: DMEM_ERR_EN.
package dmem_pkg;

  // Load-type encodings on req_load_byte (2'b11 behaves as a word load)
  localparam logic [1:0] LD_WORD  = 2'b00;
  localparam logic [1:0] LD_SBYTE = 2'b01;
  localparam logic [1:0] LD_UBYTE = 2'b10;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Default array size and its word-index width
  localparam int DEPTH_DEF = 1024;
  localparam int AW        = $clog2(DEPTH_DEF);

  // True for every load type that returns a whole word
  function automatic logic is_word_load(input logic [1:0] ld);
    return (ld != LD_SBYTE) && (ld != LD_UBYTE);
  endfunction

endpackage

// File: rtl/dmem_lane_sel.sv
// dmem_lane_sel: byte-lane steering for the data-memory responder.
// Loads: extracts the addressed lane and sign/zero extends it.
// Stores: produces the per-lane byte-enable mask and lane-replicated write data.
module dmem_lane_sel
  import dmem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  logic [1:0]  load_type,
  input  logic        wr_byte,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_data
);

  logic [7:0] lane_byte;

  // Load path: pick the little-endian lane and extend according to load type
  always_comb begin
    lane_byte = rd_word[8*lane +: 8];
    case (load_type)
      LD_SBYTE: ld_data = {{24{lane_byte[7]}}, lane_byte};
      LD_UBYTE: ld_data = {24'h000000, lane_byte};
      default:  ld_data = rd_word;
    endcase
  end

  // Store path: a byte store enables one lane and replicates the byte to all lanes
  always_comb begin
    if (wr_byte) begin
      wr_be   = 4'b0001 << lane;
      wr_data = {4{wdata[7:0]}};
    end else begin
      wr_be   = 4'b1111;
      wr_data = wdata;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the Mem-stage load/store interface.
// One request at a time over valid/ready; response after LATENCY wait cycles.
// Optional macro DMEM_ERR_EN: flags misaligned word accesses and out-of-range
// addresses with resp_err (no write, zero read data). Without it addresses wrap.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1 << AW,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [1:0]  req_load_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic [1:0]  ld_q, ld_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [IDX_W-1:0] idx;
  logic             commit;
  logic             err;
  logic [31:0]      rd_word;
  logic [31:0]      ld_data;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  assign idx = addr_q[IDX_W+1:2];

  // First cycle in RESP is the commit cycle: the array is written and read then,
  // and resp_valid rises on the following edge together with the registered read.
  assign commit = (state_q == RESP) && !resp_valid_q;

`ifdef DMEM_ERR_EN
  logic word_access;
  assign word_access = we_q ? !byte_q : is_word_load(ld_q);
  assign err = (word_access && (addr_q[1:0] != 2'b00)) || (|addr_q[31:IDX_W+2]);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[31:IDX_W+2];
  assign err = 1'b0;
`endif

  // Next-state logic: accept in IDLE, count down in WAIT, hold response in RESP
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    we_d         = we_q;
    byte_d       = byte_q;
    ld_d         = ld_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          byte_d  = req_byte;
          ld_d    = req_load_byte;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        resp_valid_d = 1'b1;
        if (resp_valid_q && resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and request-capture registers; reset drops any in-flight request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      ld_q         <= LD_WORD;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      we_q         <= we_d;
      byte_q       <= byte_d;
      ld_q         <= ld_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Array split into four byte-wide lanes so byte stores need no read-modify-write
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // Lane write and registered read, both only in the commit cycle
    always_ff @(posedge clk) begin
      if (commit) begin
        if (we_q && !err && wr_be[gi]) mem[idx] <= wr_data[8*gi +: 8];
        rd_q <= mem[idx];
      end
    end

    assign rd_word[8*gi +: 8] = rd_q;
  end

  dmem_lane_sel u_lane_sel (
    .rd_word   (rd_word),
    .lane      (addr_q[1:0]),
    .load_type (ld_q),
    .wr_byte   (byte_q),
    .wdata     (wdata_q),
    .ld_data   (ld_data),
    .wr_be     (wr_be),
    .wr_data   (wr_data)
  );

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_valid_q && err;
  assign resp_rdata = (resp_valid_q && !we_q && !err) ? ld_data : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder.
// Expected data comes from a word-array model updated with plain arithmetic.
// Honours DMEM_ERR_EN for the error rules; parameter LAT sets the latency.
module tb_dmem_responder #(
    parameter int LAT = 2
);

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic [1:0]  req_load_byte = 2'b00;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_byte      (req_byte),
    .req_load_byte (req_load_byte),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;
  logic [31:0] model [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit exp_err(input bit we, input bit bt, input logic [1:0] ld,
                                 input logic [31:0] addr);
`ifdef DMEM_ERR_EN
    bit word;
    word = we ? !bt : (ld == 2'b00 || ld == 2'b11);
    return (word && (addr % 4 != 0)) || (addr >= 32'(DEPTH * 4));
`else
    return 1'b0;
`endif
  endfunction

  // One full transaction: accept, latency, response data, optional backpressure, handshake
  task automatic txn(input bit we, input bit bt, input logic [1:0] ld,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    int          edges;
    int          idx;
    int          sh;
    int          bval;
    bit          e;
    logic [31:0] exp_d;

    e     = exp_err(we, bt, ld, addr);
    idx   = int'((addr / 4) % DEPTH);
    sh    = 8 * int'(addr % 4);
    exp_d = 32'd0;
    if (!e) begin
      if (we) begin
        if (bt) model[idx] = (model[idx] & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
        else    model[idx] = wdata;
      end else begin
        bval = int'((model[idx] >> sh) & 32'hFF);
        if (ld == 2'b01)      exp_d = (bval >= 128) ? 32'(bval - 256) : 32'(bval);
        else if (ld == 2'b10) exp_d = 32'(bval);
        else                  exp_d = model[idx];
      end
    end

    edges = 0;
    while (!req_ready && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);

    req_valid = 1'b1; req_we = we; req_byte = bt; req_load_byte = ld;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);

    edges = 0;
    while (!resp_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", 32'(edges), 32'(LAT + 1));
    check("rdata", resp_rdata, exp_d);
    check("err", {31'd0, resp_err}, {31'd0, e});
    n_txn++;
    $display("txn %0d: we=%0d byte=%0d ld=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d hold=%0d",
             n_txn, we, bt, ld, addr, wdata, resp_rdata, resp_err, edges, hold);

    for (int i = 0; i < hold; i++) begin
      // a request offered while the response is pending must be ignored
      req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0;
      req_addr = addr; req_wdata = ~wdata;
      @(posedge clk); #1;
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, exp_d);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;

    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("done_valid", {31'd0, resp_valid}, 32'd0);
    check("done_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // Accept a word store, then reset before it can commit
  task automatic reset_mid_store(input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_load_byte = 2'b00;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_valid", {31'd0, resp_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    n_txn++;
    $display("txn %0d: store addr=0x%08h wdata=0x%08h dropped by reset", n_txn, addr, wdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_rdata", resp_rdata, 32'd0);
    check("reset_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // give words 0..15 known contents
    for (int w = 0; w < 16; w++) txn(1'b1, 1'b0, 2'b00, 32'(w * 4), $urandom, 0);

    // word store / load
    txn(1'b1, 1'b0, 2'b00, 32'h10, 32'hDEADBEEF, 0);
    txn(1'b0, 1'b0, 2'b00, 32'h10, 32'd0, 0);

    // byte store over zero, then the three load flavours
    txn(1'b1, 1'b0, 2'b00, 32'h10, 32'h00000000, 0);
    txn(1'b1, 1'b1, 2'b00, 32'h11, 32'h555555AB, 0);
    txn(1'b0, 1'b0, 2'b00, 32'h10, 32'd0, 0);
    txn(1'b0, 1'b0, 2'b01, 32'h11, 32'd0, 0);
    txn(1'b0, 1'b0, 2'b10, 32'h11, 32'd0, 0);

    // backpressure for 5 cycles, then confirm the ignored store did not land
    txn(1'b0, 1'b0, 2'b00, 32'h10, 32'd0, 5);
    txn(1'b0, 1'b0, 2'b00, 32'h10, 32'd0, 0);

    // reset in the middle of a store; old value must survive
    reset_mid_store(32'h20, 32'h12345678);
    txn(1'b0, 1'b0, 2'b00, 32'h20, 32'd0, 0);

    // misaligned word load and out-of-range word store
    txn(1'b0, 1'b0, 2'b00, 32'h13, 32'd0, 0);
    txn(1'b1, 1'b0, 2'b00, 32'(DEPTH * 4), 32'hCAFEF00D, 0);
    txn(1'b0, 1'b0, 2'b00, 32'h0, 32'd0, 0);

    // randomized mix over the preloaded words, occasionally beyond the array
    for (int t = 0; t < 40; t++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a + 32'(DEPTH * 4);
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          a, $urandom, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
